seq_playback: RTL and testbench
===============================

Name: seq_playback

Overview:
- Playback engine for the Simon Says pattern register.
- Reads the 32-bit sequence word as sixteen 2-bit colour codes, code i = SEQ_IN[2i+1:2i], code 0 first.
- Flashes the first LEVEL codes to the LED driver with programmable on/off timing, then signals completion to the game controller.
- Sits between the 32-bit pattern register (writer side) and the LED/buzzer output logic (reader side).

Parameters:
- ON_CYCLES, 4, clk cycles each colour is shown (LED_EN=1); legal range ≥1.
- OFF_CYCLES, 2, clk cycles of blank gap after each colour (LED_EN=0); legal range ≥1.
- CNT_W, 16, width of the phase timer; must hold max(ON_CYCLES, OFF_CYCLES).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_PLAY  in  1  reset, synchronous, active-high.
- START  in  1  one-cycle request to begin playback; sampled only in IDLE.
- ABORT  in  1  stop playback and return to IDLE.
- LEVEL  in  5  number of colours to play, 0..31.
- SEQ_IN  in  32  sequence word from the pattern register.
- COLOR  out  2  colour code currently shown.
- LED_EN  out  1  high while a colour is being shown.
- BUSY  out  1  high whenever state ≠ IDLE.
- DONE  out  1  one-cycle pulse when playback completes normally.
- IDX  out  4  index of the current or most recent colour.

Behaviour:
- Reset (rst_PLAY=1 at a clock edge, any state, mid-playback included):
  - State goes to IDLE.
  - COLOR=0, LED_EN=0, BUSY=0, DONE=0, IDX=0.
  - Timer and snapshot register clear.
  - Reset has priority over ABORT and START.
- States: IDLE, ON, OFF, FIN.
- IDLE:
  - START=1 latches SEQ_IN into an internal snapshot, latches the effective length, and sets IDX=0.
  - Effective length = min(LEVEL,16).
  - If effective length = 0: next state FIN, nothing shown.
  - Otherwise next state ON.
  - Once latched, later changes on SEQ_IN or LEVEL have no effect on the current run.
- ON:
  - LED_EN=1; COLOR = snapshot[2*IDX+1:2*IDX].
  - Stays exactly ON_CYCLES cycles, then goes to OFF.
  - LED_EN first goes high in the cycle after START.
- OFF:
  - LED_EN=0; COLOR holds its last value.
  - Stays exactly OFF_CYCLES cycles.
  - If IDX = length-1: next state FIN.
  - Otherwise IDX increments and next state is ON.
- FIN:
  - DONE=1 for exactly one cycle, BUSY=1.
  - Next state IDLE.
- Run length: a run of length N holds BUSY for N*(ON_CYCLES+OFF_CYCLES)+1 cycles. DONE is asserted in the last of these cycles.
- ABORT=1 in ON, OFF or FIN:
  - Next state IDLE, LED_EN=0.
  - No DONE pulse; if DONE would have fired in that cycle, it is suppressed.
  - IDX holds its value.
  - ABORT in IDLE has no effect.
- START while BUSY=1 is ignored; no restart and no queuing.
- START and ABORT together in IDLE: START wins, because ABORT has no effect in IDLE.
- IDX never wraps. The maximum value reached is 15, at length 16.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan (ON_CYCLES=3, OFF_CYCLES=2):
1. Basic run:
   - Stimulus: SEQ_IN=32'h0000_00E4, LEVEL=4, START pulse at cycle 0.
   - Response: COLOR sequence 0,1,2,3, each with LED_EN high for 3 cycles and then low for 2.
   - LED_EN first high at cycle 1. DONE pulses once at cycle 21. BUSY is high in cycles 1–21.
2. Full length and clamp:
   - Stimulus: SEQ_IN=32'h1B1B_1B1B, LEVEL=20.
   - Response: exactly 16 flashes, pattern 3,2,1,0 repeated. IDX ends at 15. DONE after 81 busy cycles.
3. Zero length:
   - Stimulus: LEVEL=0, START.
   - Response: LED_EN never goes high. DONE pulses in the cycle after START. BUSY is high for 1 cycle.
4. Snapshot isolation and ignored START:
   - Stimulus: SEQ_IN changed to 32'hFFFF_FFFF and a second START pulse given in the middle of the run from scenario 1.
   - Response: output identical to scenario 1 and a single DONE.
5. Abort:
   - Stimulus: ABORT asserted during the ON phase of IDX=2.
   - Response: the next cycle has BUSY=0 and LED_EN=0, no DONE ever fires, and IDX=2 is held. A following START replays from IDX 0.
6. Reset mid-operation:
   - Stimulus: rst_PLAY high for 1 cycle during an OFF phase.
   - Response: all outputs are 0 in the next cycle. DONE never fires for the interrupted run.

Source files
------------

// File: rtl/seq_playback_if.sv
// seq_playback_if: control, sequence and LED-side signals of the Simon Says playback engine.
interface seq_playback_if;
    logic        START;
    logic        ABORT;
    logic [4:0]  LEVEL;
    logic [31:0] SEQ_IN;
    logic [1:0]  COLOR;
    logic        LED_EN;
    logic        BUSY;
    logic        DONE;
    logic [3:0]  IDX;
    modport master (output START, ABORT, LEVEL, SEQ_IN, input COLOR, LED_EN, BUSY, DONE, IDX);
    modport slave  (input START, ABORT, LEVEL, SEQ_IN, output COLOR, LED_EN, BUSY, DONE, IDX);
endinterface

// File: rtl/seq_playback.sv
// seq_playback: flashes the first min(LEVEL,16) 2-bit colour codes of a latched sequence word.
// Outputs are registered from the next-state values so the LED turns on the cycle after START.
module seq_playback #(
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input logic clk,
    input logic rst_PLAY,
    seq_playback_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_FIN} state_t;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [31:0]      r_snap, w_snap_nx;
    logic [4:0]       r_len, w_len_nx, w_len_eff;
    logic [3:0]       r_idx, w_idx_nx;
    logic [1:0]       r_color;
    logic             r_led, r_busy, r_done;
    always_comb begin
        w_len_eff = bus.LEVEL > 5'd16 ? 5'd16 : bus.LEVEL;
        w_next    = r_state;
        w_cnt_nx  = r_cnt + CNT_W'(1);
        w_snap_nx = r_snap;
        w_len_nx  = r_len;
        w_idx_nx  = r_idx;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (bus.START) begin
                    w_snap_nx = bus.SEQ_IN;
                    w_len_nx  = w_len_eff;
                    w_idx_nx  = '0;
                    w_next    = w_len_eff == 5'd0 ? S_FIN : S_ON;
                end
            end
            S_ON: if (r_cnt == ON_LAST) begin
                w_next   = S_OFF;
                w_cnt_nx = '0;
            end
            S_OFF: if (r_cnt == OFF_LAST) begin
                w_cnt_nx = '0;
                w_next   = {1'b0, r_idx} == r_len - 5'd1 ? S_FIN : S_ON;
                w_idx_nx = w_next == S_ON ? r_idx + 4'd1 : r_idx;
            end
            default: begin
                w_next   = S_IDLE;
                w_cnt_nx = '0;
            end
        endcase
        // abort overrides any transition, including the one into FIN
        if (bus.ABORT && r_state != S_IDLE) begin
            w_next   = S_IDLE;
            w_cnt_nx = '0;
            w_idx_nx = r_idx;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_PLAY) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_snap  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_color <= '0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nx;
            r_snap  <= w_snap_nx;
            r_len   <= w_len_nx;
            r_idx   <= w_idx_nx;
            r_color <= w_next == S_ON ? w_snap_nx[{w_idx_nx, 1'b0} +: 2] : r_color;
            r_led   <= w_next == S_ON;
            r_busy  <= w_next != S_IDLE;
            r_done  <= w_next == S_FIN;
        end
    end
    assign bus.COLOR  = r_color;
    assign bus.LED_EN = r_led;
    assign bus.BUSY   = r_busy;
    assign bus.DONE   = r_done;
    assign bus.IDX    = r_idx;
endmodule

// File: tb/tb_seq_playback.sv
// tb_seq_playback: randomized and directed stimulus checked against a time-offset reference model.
module tb_seq_playback;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;
    logic clk = 1'b0;
    logic rst_PLAY = 1'b0;
    seq_playback_if bus();
    seq_playback #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(16)) dut (
        .clk(clk), .rst_PLAY(rst_PLAY), .bus(bus)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    logic st = 0, ab = 0, rs = 0;
    logic [4:0]  lv = 0;
    logic [31:0] sq = 0;
    bit          m_active = 0;
    int          m_t = 0, m_len = 0;
    logic [31:0] m_snap = 0;
    logic [1:0]  m_color = 0;
    logic [3:0]  m_idx = 0;
    logic        m_led = 0, m_busy = 0, m_done = 0;
    int cyc = 0, done_cnt = 0, busy_cnt = 0, led_cnt = 0, done_at = -1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask
    // run position t counts cycles since START: colour k covers t in [k*P+1, k*P+P], completion at len*P+1
    task automatic model_step();
        if (rs) begin
            m_active = 0; m_t = 0; m_len = 0; m_snap = 0;
            m_color = 0; m_idx = 0; m_led = 0; m_busy = 0; m_done = 0;
            return;
        end
        if (!m_active) begin
            if (st) begin
                m_active = 1; m_t = 1; m_snap = sq; m_idx = 0;
                m_len = lv > 16 ? 16 : int'(lv);
            end
        end else if (ab) begin
            m_active = 0;
        end else begin
            m_t++;
            if (m_t > m_len * P + 1) m_active = 0;
        end
        m_led = 0; m_done = 0; m_busy = m_active;
        if (m_active) begin
            if (m_t == m_len * P + 1) m_done = 1;
            else begin
                int k, ph;
                k = (m_t - 1) / P;
                ph = (m_t - 1) % P;
                m_idx = 4'(k);
                m_led = ph < ON;
                m_color = 2'((m_snap >> (2 * k)) & 32'd3);
            end
        end
    endtask
    task automatic tick();
        bus.START = st; bus.ABORT = ab; bus.LEVEL = lv; bus.SEQ_IN = sq; rst_PLAY = rs;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("color", 32'(bus.COLOR), 32'(m_color));
        chk("led_en", 32'(bus.LED_EN), 32'(m_led));
        chk("busy", 32'(bus.BUSY), 32'(m_busy));
        chk("done", 32'(bus.DONE), 32'(m_done));
        chk("idx", 32'(bus.IDX), 32'(m_idx));
        if (bus.DONE) begin done_cnt++; done_at = cyc; end
        if (bus.BUSY) busy_cnt++;
        if (bus.LED_EN) led_cnt++;
        st = 0; ab = 0; rs = 0;
    endtask
    task automatic clr();
        cyc = 0; done_cnt = 0; busy_cnt = 0; led_cnt = 0; done_at = -1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    initial begin
        rs = 1; tick();
        chk("rst_color", 32'(bus.COLOR), 0);
        chk("rst_busy", 32'(bus.BUSY), 0);
        idle(2);
        clr(); sq = 32'h0000_00E4; lv = 4; st = 1; tick();
        chk("s1_first_led", 32'(bus.LED_EN), 1);
        idle(24);
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_done_at", done_at, 21);
        chk("s1_busy_cnt", busy_cnt, 21);
        chk("s1_led_cnt", led_cnt, 12);
        clr(); sq = 32'h1B1B_1B1B; lv = 20; st = 1; tick();
        idle(84);
        chk("s2_done_at", done_at, 81);
        chk("s2_busy_cnt", busy_cnt, 81);
        chk("s2_led_cnt", led_cnt, 48);
        chk("s2_idx_end", 32'(bus.IDX), 15);
        clr(); lv = 0; st = 1; tick();
        idle(4);
        chk("s3_done_at", done_at, 1);
        chk("s3_busy_cnt", busy_cnt, 1);
        chk("s3_led_cnt", led_cnt, 0);
        clr(); sq = 32'h0000_00E4; lv = 4; st = 1; tick();
        for (int i = 0; i < 24; i++) begin
            if (cyc == 8) begin sq = 32'hFFFF_FFFF; st = 1; end
            tick();
        end
        chk("s4_done_cnt", done_cnt, 1);
        chk("s4_done_at", done_at, 21);
        chk("s4_led_cnt", led_cnt, 12);
        clr(); sq = 32'h0000_00E4; lv = 4; st = 1; tick();
        for (int i = 0; i < 24; i++) begin
            if (cyc == 11) ab = 1;
            tick();
        end
        chk("s5_done_cnt", done_cnt, 0);
        chk("s5_busy_cnt", busy_cnt, 11);
        chk("s5_idx_hold", 32'(bus.IDX), 2);
        clr(); st = 1; tick();
        chk("s5_replay_idx", 32'(bus.IDX), 0);
        idle(24);
        chk("s5_replay_done", done_cnt, 1);
        clr(); sq = 32'h0000_00E4; lv = 4; st = 1; tick();
        for (int i = 0; i < 24; i++) begin
            if (cyc == 4) rs = 1;
            tick();
            if (cyc == 5) chk("s6_led_after_rst", 32'(bus.LED_EN), 0);
        end
        chk("s6_done_cnt", done_cnt, 0);
        chk("s6_busy_cnt", busy_cnt, 4);
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 149) == 0);
            lv = 5'($urandom_range(0, 31));
            sq = $urandom;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
